// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data block-RAM port arbiter.
// Owner encoding, default address width and RAM read latency live here.
package mem_port_arbiter_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_M  = 1'b1
    } owner_e;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int RAM_RD_LAT     = 1;
    localparam int STARVE_W       = 4;

    typedef struct packed {
        logic   v;
        owner_e own;
        logic   rd;
    } pend_t;

    localparam pend_t PEND_IDLE = '{v: 1'b0, own: OWN_IF, rd: 1'b0};

    function automatic logic is_read(input logic [3:0] wen);
        return (wen == 4'b0000);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and RAM-side signals of the shared instruction/data RAM port.
// slave = arbiter view, master = pipeline stages plus RAM view.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_res;
    logic [31:0]       if_rdata;
    logic              mreq;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_wen;
    logic [31:0]       m_wdata;
    logic              m_gnt;
    logic              mres;
    logic [31:0]       m_rdata;
    logic [3:0]        ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_store;
    logic [31:0]       ram_load;

    modport slave (
        input  flush, if_req, if_addr, mreq, m_addr, m_wen, m_wdata, ram_load,
        output if_gnt, if_res, if_rdata, m_gnt, mres, m_rdata,
               ram_en, ram_addr, ram_store
    );

    modport master (
        output flush, if_req, if_addr, mreq, m_addr, m_wen, m_wdata, ram_load,
        input  if_gnt, if_res, if_rdata, m_gnt, mres, m_rdata,
               ram_en, ram_addr, ram_store
    );
endinterface

// File: rtl/mem_port_arbiter_fair_pick.sv
// Two-way data-priority pick with a saturating count of data wins while fetch waits;
// fetch is forced through once the count reaches STARVE_MAX. Pick is combinational.
module arb_fair_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_i,
    input  logic if_req_i,
    input  logic mreq_i,
    output logic pick_if,
    output logic pick_m
);
    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                fetch_ok;
    logic                fetch_due;

    assign fetch_ok  = if_req_i & ~flush_i;
    assign fetch_due = fetch_ok & (starve_cnt_q == CNT_MAX);

    // Picks are held low while reset is asserted so no RAM access leaks out.
    always_comb begin
        pick_if = 1'b0;
        pick_m  = 1'b0;
        if (!reset) begin
            if (mreq_i && !fetch_due) begin
                pick_m = 1'b1;
            end else if (fetch_ok) begin
                pick_if = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (flush_i || !if_req_i || pick_if) begin
            starve_cnt_d = '0;
        end else if (pick_m && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port block RAM between fetch (read-only) and data (read/write).
// Grant is combinational; response returns RAM_RD_LAT cycles later to the granted owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    logic              pick_if;
    logic              pick_m;
    logic [ADDR_W-1:0] addr_sel;
    pend_t             pend_d;
    pend_t             pend_q [RAM_RD_LAT];
    pend_t             pend_rsp;
    logic              if_res_w;
    logic              mres_w;

    arb_fair_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (bus.flush),
        .if_req_i (bus.if_req),
        .mreq_i   (bus.mreq),
        .pick_if  (pick_if),
        .pick_m   (pick_m)
    );

    always_comb begin
        addr_sel      = '0;
        bus.ram_en    = 4'b0000;
        bus.ram_store = 32'h0;
        pend_d        = PEND_IDLE;
        if (pick_m) begin
            addr_sel      = bus.m_addr;
            bus.ram_en    = bus.m_wen;
            bus.ram_store = bus.m_wdata;
            pend_d        = '{v: 1'b1, own: OWN_M, rd: is_read(bus.m_wen)};
        end else if (pick_if) begin
            addr_sel = bus.if_addr;
            pend_d   = '{v: 1'b1, own: OWN_IF, rd: 1'b1};
        end
    end

    assign bus.ram_addr = addr_sel;
    assign bus.if_gnt   = pick_if;
    assign bus.m_gnt    = pick_m;

    // One stage per cycle of RAM read latency; the last stage lines up with ram_load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_RD_LAT; i++) begin
                pend_q[i] <= PEND_IDLE;
            end
        end else begin
            pend_q[0] <= pend_d;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                pend_q[i] <= pend_q[i-1];
            end
        end
    end

    assign pend_rsp = pend_q[RAM_RD_LAT-1];

    // A flush in the response cycle drops the fetch result; data is never cancelled.
    always_comb begin
        if_res_w     = pend_rsp.v & (pend_rsp.own == OWN_IF) & ~bus.flush;
        mres_w       = pend_rsp.v & (pend_rsp.own == OWN_M);
        bus.if_res   = if_res_w;
        bus.mres     = mres_w;
        bus.if_rdata = if_res_w ? bus.ram_load : 32'h0;
        bus.m_rdata  = (mres_w && pend_rsp.rd) ? bus.ram_load : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: per-cycle reference of the sharing rules feeds an expected-response
// queue; a negedge monitor compares grants, RAM drive and responses against it.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW   = 8;
    localparam int SMAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Block RAM stand-in: registered read, byte-enabled write.
    logic [31:0] ram [256];
    logic [31:0] ram_q;
    assign bus.ram_load = ram_q;
    always @(posedge clk) begin
        ram_q <= ram[bus.ram_addr];
        for (int b = 0; b < 4; b++)
            if (bus.ram_en[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_store[8*b +: 8];
    end

    typedef struct {
        int          due;
        bit          is_m;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model_mem [256];
    int          streak = 0;
    int          cyc    = 0;
    int          total  = 0;
    int          bad    = 0;
    int          m_run  = 0;
    bit          exp_gi = 0, exp_gm = 0;
    logic [3:0]  exp_en    = '0;
    logic [7:0]  exp_addr  = '0;
    logic [31:0] exp_store = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_idle();
        bus.flush = 0; bus.if_req = 0; bus.if_addr = '0;
        bus.mreq = 0; bus.m_addr = '0; bus.m_wen = '0; bus.m_wdata = '0;
        exp_gi = 0; exp_gm = 0; exp_en = '0; exp_addr = '0; exp_store = '0;
    endtask

    // Drive one cycle of requests and record what the sharing rules say must happen.
    task automatic drive(input logic ir, input logic [7:0] ia, input logic mr,
                         input logic [7:0] ma, input logic [3:0] we,
                         input logic [31:0] wd, input logic fl);
        bit fetch_ok;
        logic [31:0] w;
        @(posedge clk); #1;
        bus.flush = fl; bus.if_req = ir; bus.if_addr = ia;
        bus.mreq = mr; bus.m_addr = ma; bus.m_wen = we; bus.m_wdata = wd;
        fetch_ok = ir && !fl;
        exp_gm = mr && !(fetch_ok && streak == SMAX);
        exp_gi = !exp_gm && fetch_ok;
        if (exp_gi || !ir || fl) streak = 0;
        else if (exp_gm && streak < SMAX) streak++;
        exp_en = '0; exp_addr = '0; exp_store = '0;
        if (exp_gm) begin
            exp_en = we; exp_addr = ma; exp_store = wd;
            if (we == 4'b0000) begin
                sbq.push_back('{due: cyc + 1, is_m: 1'b1, data: model_mem[ma]});
            end else begin
                w = model_mem[ma];
                for (int b = 0; b < 4; b++)
                    if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
                model_mem[ma] = w;
                sbq.push_back('{due: cyc + 1, is_m: 1'b1, data: 32'h0});
            end
        end else if (exp_gi) begin
            exp_addr = ia;
            sbq.push_back('{due: cyc + 1, is_m: 1'b0, data: model_mem[ia]});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 8'h0, 0, 8'h0, 4'h0, 32'h0, 0);
    endtask

    always @(negedge clk) begin
        bit          eir, emr;
        logic [31:0] eid, emd;
        exp_t        e;
        if (reset) begin
            chk("reset_outputs", {23'b0, bus.if_gnt, bus.m_gnt, bus.if_res, bus.mres,
                |bus.if_rdata, |bus.m_rdata, |bus.ram_en, |bus.ram_addr, |bus.ram_store}, 32'h0);
            m_run = 0;
        end else begin
            chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, exp_gi});
            chk("m_gnt", {31'b0, bus.m_gnt}, {31'b0, exp_gm});
            chk("ram_en", {28'b0, bus.ram_en}, {28'b0, exp_en});
            chk("ram_addr", {24'b0, bus.ram_addr}, {24'b0, exp_addr});
            chk("ram_store", bus.ram_store, exp_store);
            if (bus.if_gnt || !bus.if_req || bus.flush) begin
                m_run = 0;
            end else if (bus.m_gnt) begin
                m_run++;
                chk("starve_bound", {31'b0, m_run <= SMAX}, 32'h1);
            end
            eir = 0; emr = 0; eid = '0; emd = '0;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (e.is_m) begin
                    emr = 1; emd = e.data;
                end else if (!bus.flush) begin
                    eir = 1; eid = e.data;
                end
            end
            chk("if_res", {31'b0, bus.if_res}, {31'b0, eir});
            chk("mres", {31'b0, bus.mres}, {31'b0, emr});
            chk("if_rdata", bus.if_rdata, eid);
            chk("m_rdata", bus.m_rdata, emd);
        end
    end

    initial begin
        bit          ip, mp, fl;
        logic [7:0]  ia, ma;
        logic [3:0]  we;
        logic [31:0] wd, v;
        set_idle();
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i] = v; model_mem[i] = v;
        end
        ram[8'h10] = 32'hDEADBEEF; model_mem[8'h10] = 32'hDEADBEEF;
        ram[8'h20] = 32'h11223344; model_mem[8'h20] = 32'h11223344;

        repeat (3) @(posedge clk);
        #3 reset = 0;

        // Single fetch read.
        drive(1, 8'h10, 0, 8'h0, 4'h0, 32'h0, 0);
        idle(2);
        // Byte store then load of the same word.
        drive(0, 8'h0, 1, 8'h20, 4'b0010, 32'h0000AB00, 0);
        drive(0, 8'h0, 1, 8'h20, 4'b0000, 32'h0, 0);
        idle(2);
        // Both held: data wins until fetch has waited STARVE_MAX grants.
        repeat (15) drive(1, 8'h10, 1, 8'h20, 4'h0, 32'h0, 0);
        idle(2);
        // Flush in the fetch response cycle, with fetch still requesting.
        drive(1, 8'h30, 0, 8'h0, 4'h0, 32'h0, 0);
        drive(1, 8'h31, 0, 8'h0, 4'h0, 32'h0, 1);
        drive(1, 8'h31, 0, 8'h0, 4'h0, 32'h0, 0);
        // Flush alongside a data grant.
        drive(1, 8'h32, 1, 8'h10, 4'h0, 32'h0, 1);
        idle(2);
        // Reset with a data read in flight.
        drive(1, 8'h12, 1, 8'h11, 4'h0, 32'h0, 0);
        @(posedge clk); #1;
        set_idle();
        #1 reset = 1;
        sbq.delete();
        streak = 0;
        repeat (2) @(posedge clk);
        #3 reset = 0;
        idle(2);
        // Alternating data / fetch with no conflicts.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(0, 8'h0, 1, 8'(i), 4'h0, 32'h0, 0);
            else            drive(1, 8'(i), 0, 8'h0, 4'h0, 32'h0, 0);
        end
        idle(2);

        // Random traffic; requesters hold their request until granted.
        ip = 0; mp = 0; ia = '0; ma = '0; we = '0; wd = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!ip) begin
                ip = ($urandom_range(0, 2) != 0);
                ia = 8'($urandom_range(0, 15));
            end
            if (!mp) begin
                mp = ($urandom_range(0, 2) != 0);
                ma = 8'($urandom_range(0, 15));
                we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                wd = $urandom;
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(ip, ia, mp, ma, we, wd, fl);
            if (exp_gi) ip = 0;
            if (exp_gm) mp = 0;
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port instruction/data block RAM between the FETCH stage (read-only) and the MEM stage (read/write) so both can live on one `blk_mem_gen` instance. It sits between the pipeline stages and the RAM. Each cycle it grants at most one request, and it routes the 1-cycle-latency RAM output back to the owner. Data accesses have priority, with a bounded-starvation guarantee for fetch and an exception-flush that cancels in-flight fetches.

## Interface
- `ADDR_W`, 8: RAM word-address width.
- `STARVE_MAX`, 4: maximum number of consecutive data grants while fetch waits; range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  exception/eret flush; cancels fetch activity this cycle.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch request issued to RAM this cycle.
- `if_res`  out  1  fetch response valid.
- `if_rdata`  out  32  fetch read data.
- `mreq`  in  1  data request.
- `m_addr`  in  ADDR_W  data word address.
- `m_wen`  in  4  byte write enables; 0000 means a read.
- `m_wdata`  in  32  store data.
- `m_gnt`  out  1  data request issued this cycle.
- `mres`  out  1  data response valid.
- `m_rdata`  out  32  load data.
- `ram_en`  out  4  RAM byte write enables (`wea`).
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_store`  out  32  RAM write data.
- `ram_load`  in  32  RAM read data, valid 1 cycle after the address.

## Operation
- **Grant (combinational, same cycle as the request).**
  - Only `mreq`: grant data.
  - Only `if_req` and `flush`=0: grant fetch.
  - Both: grant data, unless `starve_cnt`==`STARVE_MAX`, in which case grant fetch.
  - `flush`=1: `if_gnt` is forced to 0. A data request can still win that cycle.
- **RAM drive.** The winner's address goes to `ram_addr`. `ram_en` = `m_wen` only on a data grant; otherwise 0. `ram_store` = `m_wdata` on a data grant; otherwise 0. With no grant, `ram_addr`=0.
- **Pending register.** `pend_v`, `pend_own` (IF/M) and `pend_rd` are loaded on every edge from the current grant. They are cleared when there is no grant.
- **Response.**
  - `if_res` = `pend_v` & `pend_own`==IF & ~`flush`.
  - `mres` = `pend_v` & `pend_own`==M.
  - `if_rdata` = `ram_load` when `if_res`=1, else 0.
  - `m_rdata` = `ram_load` when `mres`=1 and `pend_rd`=1, else 0. A write therefore gets `mres` with `m_rdata`=0.
- **Handshake.**
  - The requester holds req, address and data stable until it sees its gnt.
  - A req still high in the cycle after a gnt is a new request. Back-to-back throughput is 1 access per cycle.
  - The requester must not use its res for anything other than the transaction it was granted for.
- **Starvation counter (`starve_cnt`, 4 bits).**
  - Increments on a data grant while `if_req`=1.
  - Clears on a fetch grant, when `if_req`=0, or when `flush`=1.
  - Saturates at `STARVE_MAX`.
- **Simultaneous events.**
  - `flush` in the cycle a fetch response is due: the response is dropped (no `if_res`).
  - `flush` together with a data grant: data is unaffected.

## Timing
- Reset values: `pend_v`=0 and `starve_cnt`=0. Every output is 0 during reset and the cycle after it, unless a combinational grant is driven by an active request after release.
- Latency: gnt in cycle N, res and rdata in cycle N+1.
- A write commits to RAM at the end of cycle N.
- Reset asserted mid-transaction: the pending response is discarded and no res is issued after release.
- At most one of `if_gnt`/`m_gnt` is high per cycle, and at most one of `if_res`/`mres`.
- Fetch is granted at least once in every `STARVE_MAX`+1 consecutive cycles with `if_req`=1 and `flush`=0.

## Structure
- Shared package holds:
  - owner constants `OWN_IF`=0, `OWN_M`=1;
  - the default `ADDR_W`;
  - the RAM read-latency constant (1).
- One sub-module, `arb_fair_pick`: the two-way priority pick plus the saturating starvation counter. Its outputs are `pick_m`/`pick_if`.
- The pending register and the response muxing stay in the top module.

## Test plan
- **Single read.** `if_req`=1, `if_addr`=0x10, RAM[0x10]=0xDEADBEEF -> `if_gnt`=1 in cycle N; `if_res`=1 and `if_rdata`=0xDEADBEEF in cycle N+1.
- **Byte store then load.** Store `m_wen`=0010, `m_wdata`=0x0000AB00 at 0x20 (old value 0x11223344), then a read of 0x20 -> `mres` at N+1 with `m_rdata`=0; `mres` at N+2 with `m_rdata`=0x1122AB44.
- **Priority and starvation.** Both requests held continuously with `STARVE_MAX`=4 -> 4 data grants, 1 fetch grant, repeating. There are never more than 4 consecutive `m_gnt`.
- **Flush in the response cycle.** Fetch granted at N, `flush`=1 at N+1 -> `if_res`=0 at N+1, and `if_gnt`=0 at N+1 even with `if_req` high.
- **Reset mid-operation.** Data read granted, `reset` pulsed asynchronously before the next edge -> no `mres` after release, `starve_cnt`=0, all outputs 0.
- **Back-to-back alternating.** Requests alternating between data and fetch, no conflicts -> one grant every cycle, each response in the next cycle with the correct owner.
